// File: rtl/vec_accumulator_if.sv
// Term stream in and result stream out of vec_accumulator.
// The slave modport is the accumulator; master is its environment.
interface vec_accumulator_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] term_dat;
  logic                     term_vld;
  logic                     term_rdy;
  logic signed [DATA_W-1:0] res_dat;
  logic                     res_sat;
  logic                     res_vld;
  logic                     res_rdy;

  modport master (
    output term_dat, term_vld, res_rdy,
    input  term_rdy, res_dat, res_sat, res_vld
  );

  modport slave (
    input  term_dat, term_vld, res_rdy,
    output term_rdy, res_dat, res_sat, res_vld
  );
endinterface

// File: rtl/vec_accumulator.sv
// Saturating signed reduction of N-term groups into one DATA_W-bit result,
// with a per-step overflow flag and valid/ready on both sides.
module vec_accumulator #(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic             clk,
  input  logic             rst,
  vec_accumulator_if.slave bus
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] acc, acc_nxt;
  logic signed [DATA_W:0]   sum;
  logic [CNT_W-1:0]         cnt;
  logic                     sat, ovf;
  logic signed [DATA_W-1:0] res_dat;
  logic                     res_sat;
  logic                     term_acc, res_acc, last;

  function automatic logic signed [DATA_W:0] add_ext(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] ae, be;
    ae = {a[DATA_W-1], a};
    be = {b[DATA_W-1], b};
    return ae + be;
  endfunction

  // Clamp the W+1-bit sum to the rail it crossed; the sign bit tells which.
  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1])
      clamp = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      clamp = s[DATA_W-1:0];
  endfunction

  assign sum     = add_ext(acc, bus.term_dat);
  assign ovf     = sum[DATA_W] != sum[DATA_W-1];
  assign acc_nxt = clamp(sum);
  assign last    = (cnt == CNT_W'(N - 1));

  assign term_acc = bus.term_vld && (state == ACC);
  assign res_acc  = bus.res_rdy && (state == OUT);

  assign bus.term_rdy = (state == ACC);
  assign bus.res_vld  = (state == OUT);
  assign bus.res_dat  = res_dat;
  assign bus.res_sat  = res_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC: if (term_acc && last) state_nxt = OUT;
      OUT: if (res_acc)          state_nxt = ACC;
      default:                   state_nxt = ACC;
    endcase
  end

  // Accumulate stage: result registers load on the edge that accepts the last term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      res_dat <= '0;
      res_sat <= 1'b0;
    end else if (term_acc) begin
      acc <= acc_nxt;
      sat <= sat | ovf;
      if (last) begin
        res_dat <= acc_nxt;
        res_sat <= sat | ovf;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (res_acc) begin
      acc <= '0;
      sat <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vec_accumulator.sv
// Randomised and directed bench for vec_accumulator at N=4 and N=1,
// checked against an integer-arithmetic model of the saturating sum.
module tb_vec_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vec_accumulator_if #(.DATA_W(16)) a ();
  vec_accumulator_if #(.DATA_W(16)) b ();

  vec_accumulator #(.DATA_W(16), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(a));
  vec_accumulator #(.DATA_W(16), .N(1)) dut1 (.clk(clk), .rst(rst), .bus(b));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Model: plain integer sum, clamped to the 16-bit rails after every term.
  function automatic int model(input int t[4], input int n, output bit s);
    int acc;
    acc = 0;
    s   = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + t[i];
      if (acc > 32767)       begin acc = 32767;  s = 1'b1; end
      else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    end
    return acc;
  endfunction

  // Drives n terms on consecutive edges into the N=4 instance; starts and ends on a negedge.
  task automatic feed(input logic [15:0] t[4], input int n);
    for (int i = 0; i < n; i++) begin
      a.term_dat = t[i];
      a.term_vld = 1'b1;
      @(negedge clk);
    end
    a.term_vld = 1'b0;
    a.term_dat = 16'($urandom);
  endtask

  task automatic test_reset();
    tests++;
    if (a.res_vld !== 1'b0 || a.res_dat !== 16'h0 || a.res_sat !== 1'b0 || a.term_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: vld=%b dat=%h sat=%b rdy=%b, required 0 0000 0 1",
               a.res_vld, a.res_dat, a.res_sat, a.term_rdy);
    end
    tests++;
    if (b.res_vld !== 1'b0 || b.term_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_state_n1: vld=%b rdy=%b, required 0 1", b.res_vld, b.term_rdy);
    end
  endtask

  task automatic test_basic();
    a.res_rdy = 1'b1;
    feed('{16'd1, 16'd2, 16'd3, 16'd4}, 4);
    tests++;
    if (a.res_vld !== 1'b1 || a.res_dat !== 16'd10 || a.res_sat !== 1'b0 || a.term_rdy !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: vld=%b dat=%0d sat=%b rdy=%b, required 1 10 0 0",
               a.res_vld, a.res_dat, a.res_sat, a.term_rdy);
    end
    @(negedge clk);
    tests++;
    if (a.res_vld !== 1'b0 || a.term_rdy !== 1'b1) begin
      fails++;
      $display("FAIL basic_release: vld=%b rdy=%b, required 0 1", a.res_vld, a.term_rdy);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] groups [3][4];
    logic [15:0] exp_dat [3];
    groups[0] = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
    groups[1] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000};
    groups[2] = '{16'h7FFF, 16'h0001, 16'hFFFF, 16'h0000};
    exp_dat   = '{16'h7FFF, 16'h8000, 16'h7FFE};
    a.res_rdy = 1'b1;
    for (int g = 0; g < 3; g++) begin
      feed(groups[g], 4);
      tests++;
      if (a.res_vld !== 1'b1 || a.res_dat !== exp_dat[g] || a.res_sat !== 1'b1) begin
        fails++;
        $display("FAIL saturation_%0d: vld=%b dat=%h sat=%b, required 1 %h 1",
                 g, a.res_vld, a.res_dat, a.res_sat, exp_dat[g]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure_gaps();
    logic [15:0] t [4];
    t = '{16'd5, 16'd6, 16'd7, 16'd8};
    a.res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.term_dat = t[i];
      a.term_vld = 1'b1;
      @(negedge clk);
      if (i < 3) begin
        a.term_vld = 1'b0;
        a.term_dat = 16'h1234;
        tests++;
        if (a.term_rdy !== 1'b1 || a.res_vld !== 1'b0) begin
          fails++;
          $display("FAIL gap_%0d: rdy=%b vld=%b, required 1 0", i, a.term_rdy, a.res_vld);
        end
        @(negedge clk);
      end
    end
    for (int k = 0; k < 5; k++) begin
      a.term_vld = (k % 2 == 0);
      a.term_dat = 16'd1000;
      tests++;
      if (a.res_vld !== 1'b1 || a.res_dat !== 16'd26 || a.res_sat !== 1'b0 || a.term_rdy !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: vld=%b dat=%0d sat=%b rdy=%b, required 1 26 0 0",
                 k, a.res_vld, a.res_dat, a.res_sat, a.term_rdy);
      end
      @(negedge clk);
    end
    a.term_vld = 1'b0;
    a.res_rdy  = 1'b1;
    @(negedge clk);
    tests++;
    if (a.res_vld !== 1'b0 || a.term_rdy !== 1'b1 || a.res_dat !== 16'd26) begin
      fails++;
      $display("FAIL bp_release: vld=%b rdy=%b dat=%0d, required 0 1 26", a.res_vld, a.term_rdy, a.res_dat);
    end
    feed('{16'd2, 16'd3, 16'd4, 16'd5}, 4);
    tests++;
    if (a.res_vld !== 1'b1 || a.res_dat !== 16'd14 || a.res_sat !== 1'b0) begin
      fails++;
      $display("FAIL fresh_group: vld=%b dat=%0d sat=%b, required 1 14 0", a.res_vld, a.res_dat, a.res_sat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a.res_rdy = 1'b1;
    feed('{16'd100, 16'd200, 16'd0, 16'd0}, 2);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (a.res_vld !== 1'b0 || a.res_dat !== 16'h0 || a.res_sat !== 1'b0 || a.term_rdy !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: vld=%b dat=%h sat=%b rdy=%b, required 0 0000 0 1",
               a.res_vld, a.res_dat, a.res_sat, a.term_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    feed('{16'd1, 16'd1, 16'd1, 16'd1}, 4);
    tests++;
    if (a.res_vld !== 1'b1 || a.res_dat !== 16'd4 || a.res_sat !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: vld=%b dat=%0d sat=%b, required 1 4 0", a.res_vld, a.res_dat, a.res_sat);
    end
    @(negedge clk);
  endtask

  task automatic test_n1();
    b.res_rdy  = 1'b1;
    b.term_dat = 16'h8000;
    b.term_vld = 1'b1;
    @(negedge clk);
    b.term_dat = 16'h7FFF;
    tests++;
    if (b.res_vld !== 1'b1 || b.res_dat !== 16'h8000 || b.res_sat !== 1'b0 || b.term_rdy !== 1'b0) begin
      fails++;
      $display("FAIL n1_first: vld=%b dat=%h sat=%b rdy=%b, required 1 8000 0 0",
               b.res_vld, b.res_dat, b.res_sat, b.term_rdy);
    end
    @(negedge clk);
    tests++;
    if (b.res_vld !== 1'b0 || b.term_rdy !== 1'b1) begin
      fails++;
      $display("FAIL n1_gap: vld=%b rdy=%b, required 0 1", b.res_vld, b.term_rdy);
    end
    @(negedge clk);
    b.term_vld = 1'b0;
    tests++;
    if (b.res_vld !== 1'b1 || b.res_dat !== 16'h7FFF || b.res_sat !== 1'b0) begin
      fails++;
      $display("FAIL n1_second: vld=%b dat=%h sat=%b, required 1 7fff 0", b.res_vld, b.res_dat, b.res_sat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] t [4];
    int          ti [4];
    int          exp_v;
    bit          exp_s;
    int          bp;
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       t[i] = 16'h7FFF - 16'($urandom_range(0, 4000));
          1:       t[i] = 16'h8000 + 16'($urandom_range(0, 4000));
          default: t[i] = 16'($urandom);
        endcase
        ti[i] = int'($signed(t[i]));
      end
      exp_v = model(ti, 4, exp_s);
      a.res_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          a.term_vld = 1'b0;
          a.term_dat = 16'($urandom);
          @(negedge clk);
        end
        tests++;
        if (a.term_rdy !== 1'b1) begin
          fails++;
          $display("FAIL rand_rdy_g%0d_t%0d: rdy=%b, required 1", g, i, a.term_rdy);
        end
        a.term_dat = t[i];
        a.term_vld = 1'b1;
        @(negedge clk);
      end
      a.term_vld = 1'b0;
      bp = $urandom_range(0, 3);
      a.res_rdy = (bp == 0);
      repeat (bp) @(negedge clk);
      tests++;
      if (a.res_vld !== 1'b1 || a.res_dat !== 16'(exp_v) || a.res_sat !== exp_s) begin
        fails++;
        $display("FAIL rand_group_%0d: vld=%b dat=%h sat=%b, required 1 %h %b",
                 g, a.res_vld, a.res_dat, a.res_sat, 16'(exp_v), exp_s);
      end
      a.res_rdy = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    a.term_dat = '0; a.term_vld = 1'b0; a.res_rdy = 1'b1;
    b.term_dat = '0; b.term_vld = 1'b0; b.res_rdy = 1'b1;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_saturation();
    test_backpressure_gaps();
    test_reset_mid();
    test_n1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
